// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared constants for the bit-serial adder. Holds the FSM
//                state encoding and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // FSM state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_fa_cell
//  Description : Purely combinational 1-bit full adder. The single
//                arithmetic cell used by the bit-serial adder.
//  Ports       : a, b  - operand bits
//                ci    - carry in
//                s     - sum bit
//                co    - carry out (majority of a, b, ci)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Parametrised bit-serial adder. Adds A + B + Cin one bit per
//                clock, LSB first, through a single full-adder cell and a
//                carry flip-flop. Start/done handshake; results are held on
//                registered outputs until the next operation completes.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                start - request, sampled only in IDLE
//                A, B  - operands, captured on accepted start
//                Cin   - carry-in, captured on accepted start
//                busy  - high whenever the FSM is not IDLE
//                done  - one-cycle pulse, result valid
//                Sum   - registered sum
//                Cout  - carry-out of the MSB (unsigned overflow)
//                Ovf   - signed overflow (carry into MSB ^ carry out of MSB)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  // Single arithmetic cell: always looks at the current LSBs and carry.
  serial_adder_fa_cell u_fa_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (state == S_RUN) && (cnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath: operand/sum shift registers, carry and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      // Sum bits enter at the MSB so after WIDTH shifts bit 0 is at the LSB.
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: updated only on the final RUN edge, held otherwise
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (last_bit) begin
      Sum  <= {fa_s, sum_sr[WIDTH-1:1]};
      Cout <= fa_co;
      // On the MSB step the carry register still holds the carry into the MSB.
      Ovf  <= carry ^ fa_co;
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder. Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through a single 1-bit full-adder cell and a carry flip-flop.
- Start/done handshake. Results are held on registered outputs.
- Area-cheap successor to the team's combinational 1-bit full adder. Intended for datapaths where add latency is tolerable but gate count is not.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; not overridden by users.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A; captured on accepted start
- B  in  WIDTH  operand B; captured on accepted start
- Cin  in  1  carry-in; captured on accepted start
- busy  out  1  high when state is not IDLE
- done  out  1  single-cycle pulse, result valid
- Sum  out  WIDTH  registered sum; held until next result
- Cout  out  1  carry-out of the MSB
- Ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, deassert sync to clk):
  - state=IDLE; shift regs, carry and counter cleared.
  - Outputs: busy=0, done=0, Sum=0, Cout=0, Ovf=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge loads a_sr<=A, b_sr<=B, carry<=Cin, cnt<=0; state -> RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right; s shifts into sum_sr MSB.
  - cnt++.
  - On the edge where cnt==WIDTH-1: capture Ovf_next = carry(current, i.e. carry into MSB) XOR new carry. Load Sum<=final sum_sr, Cout<=new carry, Ovf<=Ovf_next. State -> DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the start-sampling edge, i.e. WIDTH edges after acceptance.
- Throughput: one operation per WIDTH+2 cycles when start is held high continuously.
- start in RUN or DONE: ignored, no queuing. A, B and Cin may change freely after acceptance.
- Sum/Cout/Ovf change only on the RUN->DONE edge. Stable otherwise, including throughout the next operation.
- Reset mid-operation: abort immediately to reset values. No done pulse. The partial result is discarded.
- Unsigned and signed interpretations both valid. Cout serves unsigned, Ovf serves two's-complement.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module fa_cell: purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once.
- Top block holds the FSM, counter, operand shift registers, carry register and output registers.

Test Plan (WIDTH=8):
- Reset, then A=0x0F, B=0x01, Cin=0, start 1 cycle -> busy high next cycle; done after 8 edges; Sum=0x10, Cout=0, Ovf=0.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Ovf=0. Then A=0x00, B=0x00, Cin=1 -> Sum=0x01, Cout=0.
- A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, Ovf=1. A=0x80, B=0x80 -> Sum=0x00, Cout=1, Ovf=1.
- Start pulse (A=0x11, B=0x22) accepted; mid-RUN assert start with A=0xAA, B=0x55 -> ignored; single done; Sum=0x33. Previous Sum stays stable until the done edge.
- Start held high continuously -> done pulses every 10 cycles. Operands sampled only at IDLE edges. Each result matches a reference model.
- Drive rst_n low at RUN cycle 4 -> outputs immediately 0, no done. After release, a new op A=0x01, B=0x02 -> Sum=0x03. Finish with a random sweep of 1000 ops against the model.
